// File: rtl/sparc_mem_sequencer_pkg.sv
// Shared type codes, FSM encodings and access-size helpers for the SPARC RAM sequencer.
package sparc_mem_sequencer_pkg;

    localparam logic [1:0] TYPE_BYTE = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_WORD = 2'b10;
    localparam logic [1:0] TYPE_ILL  = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_HOLD    = 3'd5;

    // Index of the final byte cycle (n-1) for an access size.
    function automatic logic [1:0] last_idx(input logic [1:0] typ);
        case (typ)
            TYPE_WORD: last_idx = 2'd3;
            TYPE_HALF: last_idx = 2'd1;
            default:   last_idx = 2'd0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] typ, input logic [1:0] a_lo);
        misaligned = ((typ == TYPE_HALF) && a_lo[0]) ||
                     ((typ == TYPE_WORD) && (a_lo != 2'b00));
    endfunction

endpackage

// File: rtl/sparc_mem_sequencer_byte_lane.sv
// Big-endian lane select for writes and lane merge for reads.
// Combinational, zero latency; no flow control.
// Backpressure: none, purely a function of its inputs.
module sparc_byte_lane
    import sparc_mem_sequencer_pkg::*;
(
    input  logic [1:0]  typ,
    input  logic [1:0]  idx,
    input  logic [31:0] wdata,
    input  logic [31:0] acc,
    input  logic [7:0]  rbyte,
    output logic [7:0]  wbyte,
    output logic [31:0] acc_nxt
);

    // Byte idx 0 is the most significant byte of the n-byte value.
    logic [1:0] lane;
    assign lane = last_idx(typ) - idx;

    always_comb begin
        wbyte   = 8'h00;
        acc_nxt = acc;
        case (lane)
            2'd0: begin wbyte = wdata[7:0];   acc_nxt[7:0]   = rbyte; end
            2'd1: begin wbyte = wdata[15:8];  acc_nxt[15:8]  = rbyte; end
            2'd2: begin wbyte = wdata[23:16]; acc_nxt[23:16] = rbyte; end
            default: begin wbyte = wdata[31:24]; acc_nxt[31:24] = rbyte; end
        endcase
    end

endmodule

// File: rtl/sparc_mem_sequencer.sv
// Splits CPU byte/half/word and loader byte requests into MOV/MOC byte cycles on the RAM.
// Latency: 3 cycles per byte plus accept and DONE (byte 5, word 14 with immediate ram_moc).
// Backpressure: requesters hold their level request until cpu_moc / ld_ack; RAM stalls via ram_moc.
module sparc_mem_sequencer
    import sparc_mem_sequencer_pkg::*;
#(
    parameter int AW          = 9,
    parameter int MOC_TIMEOUT = 15
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          cpu_mov,
    input  logic          cpu_rw,
    input  logic [1:0]    cpu_type,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_moc,
    output logic          cpu_err,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          ld_ack,
    output logic          ram_mov,
    output logic          ram_rw,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata,
    input  logic          ram_moc,
    output logic          busy
);

    logic [2:0]    state;
    logic [1:0]    idx;
    logic [1:0]    typ;
    logic [3:0]    tcnt;
    logic [AW-1:0] base;
    logic          rw;
    logic          is_ld;
    logic          err;
    logic [31:0]   wdat;
    logic [31:0]   acc;
    logic [31:0]   rdata_q;

    logic [7:0]    wbyte;
    logic [31:0]   acc_nxt;
    logic [3:0]    tcnt_inc;
    logic          timeout;
    logic          bad_req;

    sparc_byte_lane u_lane (
        .typ     (typ),
        .idx     (idx),
        .wdata   (wdat),
        .acc     (acc),
        .rbyte   (ram_rdata),
        .wbyte   (wbyte),
        .acc_nxt (acc_nxt)
    );

    assign tcnt_inc = tcnt + 4'd1;
    assign timeout  = (tcnt_inc == 4'(MOC_TIMEOUT));
    assign bad_req  = (cpu_type == TYPE_ILL) || misaligned(cpu_type, cpu_addr[1:0]);

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state   <= ST_IDLE;
            idx     <= 2'd0;
            typ     <= TYPE_BYTE;
            tcnt    <= 4'd0;
            base    <= '0;
            rw      <= 1'b0;
            is_ld   <= 1'b0;
            err     <= 1'b0;
            wdat    <= 32'h0;
            acc     <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Loader has priority so boot images are never starved by the CPU.
                    if (ld_req) begin
                        base  <= ld_addr;
                        rw    <= 1'b0;
                        typ   <= TYPE_BYTE;
                        wdat  <= {24'h0, ld_data};
                        is_ld <= 1'b1;
                        err   <= 1'b0;
                        idx   <= 2'd0;
                        acc   <= 32'h0;
                        state <= ST_ISSUE;
                    end else if (cpu_mov) begin
                        base  <= cpu_addr;
                        rw    <= cpu_rw;
                        typ   <= cpu_type;
                        wdat  <= cpu_wdata;
                        is_ld <= 1'b0;
                        err   <= bad_req;
                        idx   <= 2'd0;
                        acc   <= 32'h0;
                        state <= bad_req ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tcnt  <= 4'd0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ram_moc) begin
                        if (rw) acc <= acc_nxt;
                        state <= ST_RELEASE;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= ST_RELEASE;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                ST_RELEASE: begin
                    if ((idx == last_idx(typ)) || err) begin
                        // Publish read data as DONE begins so it is valid alongside cpu_moc.
                        if (rw && !err && !is_ld) rdata_q <= acc;
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= ST_ISSUE;
                    end
                end
                ST_DONE: state <= is_ld ? ST_IDLE : ST_HOLD;
                ST_HOLD: if (!cpu_mov) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ram_mov   = (state == ST_ISSUE) || (state == ST_WAIT);
    assign ram_rw    = ram_mov && rw;
    assign ram_addr  = ram_mov ? (base + AW'(idx)) : '0;
    assign ram_wdata = (ram_mov && !rw) ? wbyte : 8'h00;
    assign cpu_moc   = (state == ST_DONE) && !is_ld;
    assign cpu_err   = cpu_moc && err;
    assign ld_ack    = (state == ST_DONE) && is_ld;
    assign busy      = (state != ST_IDLE);
    assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_sparc_mem_sequencer.sv
// Directed bench for sparc_mem_sequencer: RAM responder, transaction-level model and scoreboard.
module tb_sparc_mem_sequencer;
    import sparc_mem_sequencer_pkg::*;

    logic        Clk = 1'b0;
    logic        Clr = 1'b0;
    logic        cpu_mov = 1'b0, cpu_rw = 1'b0;
    logic [1:0]  cpu_type = 2'b00;
    logic [8:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_moc, cpu_err;
    logic        ld_req = 1'b0;
    logic [8:0]  ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        ld_ack;
    logic        ram_mov, ram_rw;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic        ram_moc = 1'b0;
    logic        busy;

    always #5 Clk = ~Clk;

    sparc_mem_sequencer #(.AW(9), .MOC_TIMEOUT(15)) dut (
        .Clk(Clk), .Clr(Clr),
        .cpu_mov(cpu_mov), .cpu_rw(cpu_rw), .cpu_type(cpu_type), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_moc(cpu_moc), .cpu_err(cpu_err),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
        .ram_mov(ram_mov), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_moc(ram_moc), .busy(busy)
    );

    // RAM responder: ram_moc after (1 + moc_dly) cycles of ram_mov beyond the issue cycle.
    logic [7:0] mem [512];
    int  moc_dly = 0;
    bit  stall = 0;
    int  mov_k = 0;
    always @(negedge Clk) begin
        if (!ram_mov) begin
            ram_moc = 1'b0;
            mov_k   = 0;
        end else begin
            mov_k++;
            if (!ram_moc && !stall && mov_k >= 2 + moc_dly) begin
                if (ram_rw) ram_rdata = mem[ram_addr];
                else        mem[ram_addr] = ram_wdata;
                ram_moc = 1'b1;
            end
        end
    end

    // Transaction-level model state
    logic [7:0]  mdl_mem [512];
    int          q_addr[$];
    bit          q_rw[$];
    logic [7:0]  q_dat[$];
    bit          exp_pending = 0, exp_err = 0, exp_upd = 0, ld_pending = 0;
    logic [31:0] exp_rdata = '0, mdl_rdata = '0;
    int          exp_lat = 0;
    int          checks = 0, failures = 0;
    int          pulse_cnt = 0, hi_cnt = 0, last_hi = 0;
    int          c_a;
    bit          c_r;
    logic [7:0]  c_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Clr) begin
            if (ram_mov) begin
                if (hi_cnt == 0) begin
                    pulse_cnt++;
                    chk("ram_cycle_expected", 32'(q_addr.size() != 0), 32'd1);
                    if (q_addr.size() != 0) begin
                        c_a = q_addr.pop_front();
                        c_r = q_rw.pop_front();
                        c_d = q_dat.pop_front();
                        chk("ram_addr", 32'(ram_addr), c_a);
                        chk("ram_rw", 32'(ram_rw), 32'(c_r));
                        if (!c_r) begin
                            chk("ram_wdata", 32'(ram_wdata), 32'(c_d));
                            mdl_mem[c_a] = c_d;
                        end
                    end
                end
                hi_cnt++;
            end else if (hi_cnt != 0) begin
                last_hi = hi_cnt;
                hi_cnt  = 0;
            end
            if (cpu_moc) begin
                chk("cpu_moc_expected", 32'(exp_pending), 32'd1);
                if (exp_pending) begin
                    chk("cpu_err", 32'(cpu_err), 32'(exp_err));
                    if (exp_upd) mdl_rdata = exp_rdata;
                    chk("cpu_rdata", cpu_rdata, mdl_rdata);
                    exp_pending = 0;
                end
            end
            if (ld_ack) begin
                chk("ld_ack_expected", 32'(ld_pending), 32'd1);
                ld_pending = 0;
            end
        end else begin
            hi_cnt = 0;
        end
    end

    // Expected byte cycles, error and read data of one CPU request.
    task automatic prep_cpu(input bit rw, input logic [1:0] typ, input int addr, input logic [31:0] wdata);
        int n;
        int a;
        bit bad;
        n   = (typ == TYPE_WORD) ? 4 : (typ == TYPE_HALF) ? 2 : 1;
        bad = (typ == TYPE_ILL) || (typ == TYPE_HALF && addr % 2 != 0) ||
              (typ == TYPE_WORD && addr % 4 != 0);
        exp_err   = bad || stall;
        exp_upd   = rw && !exp_err;
        exp_rdata = 32'h0;
        if (!bad) begin
            for (int i = 0; i < (stall ? 1 : n); i++) begin
                a = (addr + i) % 512;
                q_addr.push_back(a);
                q_rw.push_back(rw);
                q_dat.push_back(8'((wdata >> (8 * (n - 1 - i))) & 32'hFF));
                exp_rdata = exp_rdata | (32'(mdl_mem[a]) << (8 * (n - 1 - i)));
            end
        end
        exp_lat     = bad ? 2 : stall ? 19 : 2 + (3 + moc_dly) * n;
        exp_pending = 1;
        cpu_rw      = rw;
        cpu_type    = typ;
        cpu_addr    = 9'(addr);
        cpu_wdata   = wdata;
    endtask

    task automatic wait_moc(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            n++;
            if (cpu_moc) break;
        end
        chk("cpu_moc_seen", 32'(cpu_moc), 32'd1);
    endtask

    task automatic cpu_txn(input bit rw, input logic [1:0] typ, input int addr,
                           input logic [31:0] wdata, output int lat);
        prep_cpu(rw, typ, addr, wdata);
        cpu_mov = 1'b1;
        wait_moc(lat);
        chk("latency", lat, exp_lat);
        cpu_mov = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int lat, p0, ld_n, moc_n, nbad;

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            mdl_mem[i] = 8'(i * 7 + 3);
        end
        #12;
        chk("reset_ctrl", {26'h0, ram_mov, ram_rw, cpu_moc, cpu_err, ld_ack, busy}, 32'h0);
        chk("reset_rdata", cpu_rdata, 32'h0);
        chk("reset_ram_bus", {15'h0, ram_addr, ram_wdata}, 32'h0);
        @(posedge Clk); #1 Clr = 1'b1;
        @(posedge Clk); #1;

        // Word write, four byte cycles, big-endian placement
        p0 = pulse_cnt;
        cpu_txn(1'b0, TYPE_WORD, 'h010, 32'hDEADBEEF, lat);
        chk("t1_latency", lat, 14);
        chk("t1_pulses", pulse_cnt - p0, 4);
        chk("t1_ram_bytes", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEADBEEF);

        // Reads of each size
        cpu_txn(1'b1, TYPE_WORD, 'h010, 32'h0, lat);
        chk("t2_word", cpu_rdata, 32'hDEADBEEF);
        cpu_txn(1'b1, TYPE_HALF, 'h012, 32'h0, lat);
        chk("t2_half", cpu_rdata, 32'h0000BEEF);
        chk("t2_half_latency", lat, 8);
        moc_dly = 2;
        cpu_txn(1'b0, TYPE_HALF, 'h040, 32'hFFFF1234, lat);
        chk("t2_slow_half_latency", lat, 12);
        chk("t2_slow_half_bytes", {16'h0, mem[64], mem[65]}, 32'h00001234);
        moc_dly = 1;
        cpu_txn(1'b1, TYPE_HALF, 'h040, 32'h0, lat);
        chk("t2_slow_half_read", cpu_rdata, 32'h00001234);
        moc_dly = 0;
        cpu_txn(1'b1, TYPE_BYTE, 'h011, 32'h0, lat);
        chk("t2_byte", cpu_rdata, 32'h000000AD);
        chk("t2_byte_latency", lat, 5);

        // Misaligned and illegal requests never touch the RAM
        p0 = pulse_cnt;
        cpu_txn(1'b0, TYPE_HALF, 'h013, 32'h0000AAAA, lat);
        chk("t3_half_mis_latency", lat, 2);
        cpu_txn(1'b1, TYPE_WORD, 'h012, 32'h0, lat);
        chk("t3_word_mis_latency", lat, 2);
        cpu_txn(1'b1, TYPE_ILL, 'h020, 32'h0, lat);
        chk("t3_ill_latency", lat, 2);
        chk("t3_no_ram_cycles", pulse_cnt - p0, 0);
        chk("t3_rdata_held", cpu_rdata, 32'h000000AD);

        // RAM never answers
        stall = 1;
        p0 = pulse_cnt;
        cpu_txn(1'b1, TYPE_BYTE, 'h030, 32'h0, lat);
        stall = 0;
        chk("t5_latency", lat, 19);
        chk("t5_mov_width", last_hi, 16);
        chk("t5_pulses", pulse_cnt - p0, 1);
        chk("t5_rdata_held", cpu_rdata, 32'h000000AD);

        // Loader and CPU request together: loader first
        ld_pending = 1;
        q_addr.push_back('h100);
        q_rw.push_back(1'b0);
        q_dat.push_back(8'h5C);
        prep_cpu(1'b0, TYPE_BYTE, 'h101, 32'h00000077);
        ld_req  = 1'b1;
        ld_addr = 9'h100;
        ld_data = 8'h5C;
        cpu_mov = 1'b1;
        ld_n = 0;
        moc_n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge Clk);
            if (ld_ack) begin
                ld_n   = i;
                ld_req = 1'b0;
            end
            if (cpu_moc) begin
                moc_n = i;
                break;
            end
        end
        cpu_mov = 1'b0;
        @(posedge Clk); @(posedge Clk); #1;
        chk("t4_ld_ack_cycle", ld_n, 5);
        chk("t4_cpu_moc_cycle", moc_n, 10);
        chk("t4_ld_done", 32'(ld_pending), 32'd0);
        chk("t4_ram_bytes", {16'h0, mem[256], mem[257]}, 32'h00005C77);

        // Reset during the second byte of a word write
        prep_cpu(1'b0, TYPE_WORD, 'h020, 32'h11223344);
        cpu_mov = 1'b1;
        repeat (6) @(negedge Clk);
        #2 Clr = 1'b0;
        cpu_mov = 1'b0;
        #1;
        chk("t6_reset_idle", {30'h0, ram_mov, busy}, 32'h0);
        chk("t6_rdata_cleared", cpu_rdata, 32'h0);
        exp_pending = 0;
        mdl_rdata   = 32'h0;
        q_addr.delete();
        q_rw.delete();
        q_dat.delete();
        @(posedge Clk); #1 Clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("t6_no_moc", {30'h0, cpu_moc, ld_ack}, 32'h0);
        end
        @(posedge Clk); #1;
        cpu_txn(1'b1, TYPE_WORD, 'h020, 32'h0, lat);
        chk("t6_after_reset_read", cpu_rdata, 32'h1122F1F8);
        chk("t6_after_reset_latency", lat, 14);

        nbad = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== mdl_mem[i]) nbad++;
        chk("mem_vs_model", nbad, 0);
        chk("no_leftover_cycles", q_addr.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
